// File: rtl/paralelo_serial_tx.sv
// paralelo_serial_tx: 8-bit parallel to MSB-first serial transmitter with comma sync/idle fill
// Optional TX_BYTE_COUNT_EN adds a 16-bit count of data words sent.
module paralelo_serial_tx #(
  parameter logic [7:0] COMMA = 8'hBC,
  parameter int SYNC_COUNT = 4
) (
  input  logic        clk_32f,
  input  logic        reset_L,
  input  logic [7:0]  data_in,
  input  logic        valid_in,
  output logic        ready_out,
`ifdef TX_BYTE_COUNT_EN
  output logic [15:0] byte_count,
`endif
  output logic        data_out
);
  localparam int SW = $clog2(SYNC_COUNT + 1);
  localparam logic [SW-1:0] SC = SW'(SYNC_COUNT);
  typedef enum logic {SYNC, ACTIVE} state_t;
  state_t state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [SW-1:0] sync_cnt_q, sync_cnt_d;
  logic load;
  assign load = bit_cnt_q == 3'd7;
  assign data_out = shreg_q[7];
  assign ready_out = load && state_q == ACTIVE;
  always_comb begin
    shreg_d = {shreg_q[6:0], 1'b0};
    bit_cnt_d = bit_cnt_q + 3'd1;
    sync_cnt_d = sync_cnt_q;
    state_d = state_q;
    if (load && state_q == SYNC) begin
      shreg_d = COMMA;
      sync_cnt_d = sync_cnt_q == SC ? SC : sync_cnt_q + SW'(1);
      state_d = sync_cnt_q + SW'(1) == SC ? ACTIVE : SYNC;
    end else if (load) begin
      shreg_d = valid_in ? data_in : COMMA;
    end
  end
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      shreg_q <= 8'h00;
      bit_cnt_q <= 3'd7;
      sync_cnt_q <= '0;
      state_q <= SYNC;
    end else begin
      shreg_q <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      sync_cnt_q <= sync_cnt_d;
      state_q <= state_d;
    end
  end
`ifdef TX_BYTE_COUNT_EN
  logic [15:0] byte_count_q, byte_count_d;
  assign byte_count = byte_count_q;
  assign byte_count_d = ready_out && valid_in ? byte_count_q + 16'd1 : byte_count_q;
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) byte_count_q <= 16'd0;
    else byte_count_q <= byte_count_d;
  end
`endif
endmodule

// File: tb/tb_paralelo_serial_tx.sv
// tb_paralelo_serial_tx: scoreboard bench for paralelo_serial_tx (sync, data, idle, async reset)
module tb_paralelo_serial_tx;
  logic clk_32f = 1'b0;
  logic reset_L = 1'b0;
  logic valid_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic ready_out, data_out;
`ifdef TX_BYTE_COUNT_EN
  logic [15:0] byte_count;
`endif
  int errors = 0;
  int checks = 0;
  int n = 0;
  logic exp_q[$];
  logic [8:0] stim[$];
  always #5 clk_32f = ~clk_32f;
  paralelo_serial_tx dut (
    .clk_32f(clk_32f),
    .reset_L(reset_L),
    .data_in(data_in),
    .valid_in(valid_in),
    .ready_out(ready_out),
`ifdef TX_BYTE_COUNT_EN
    .byte_count(byte_count),
`endif
    .data_out(data_out)
  );
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%h exp=%h", tag, n, got, exp);
    end
  endtask
  task automatic push_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) exp_q.push_back(w[i]);
  endtask
  // Called at a falling edge after edge n: check outputs, then drive inputs for edge n+1.
  task automatic step();
    logic [8:0] s;
    int slot;
    if (n == 0) check("data_out_rst", 16'(data_out), 16'd0);
    else if (exp_q.size() == 0) check("sb_empty", 16'd1, 16'd0);
    else check("data_out", 16'(data_out), 16'(exp_q.pop_front()));
    check("ready_out", 16'(ready_out), 16'(n >= 32 && n % 8 == 0));
    if (n % 8 == 0) begin
      slot = n / 8;
      if (slot < 4) begin
        valid_in = 1'b1;
        data_in = 8'h13;
        push_word(8'hBC);
      end else begin
        s = (slot - 4 < stim.size()) ? stim[slot - 4] : 9'h000;
        valid_in = s[8];
        data_in = s[7:0];
        push_word(s[8] ? s[7:0] : 8'hBC);
      end
    end else begin
      valid_in = 1'($urandom_range(1));
      data_in = 8'h13 ^ 8'($urandom);
    end
    @(posedge clk_32f);
    n++;
    @(negedge clk_32f);
  endtask
  task automatic do_reset();
    reset_L = 1'b0;
    valid_in = 1'b0;
    @(negedge clk_32f);
    check("rst_data_out", 16'(data_out), 16'd0);
    check("rst_ready_out", 16'(ready_out), 16'd0);
    exp_q.delete();
    n = 0;
    reset_L = 1'b1;
  endtask
  initial begin
    stim = '{9'h1F2, 9'h115, 9'h1DD, 9'h145, 9'h000, 9'h1AA, 9'h000, 9'h1EE, 9'h1BC, 9'h000};
    do_reset();
    repeat ((4 + stim.size() + 2) * 8) step();
`ifdef TX_BYTE_COUNT_EN
    check("byte_count", byte_count, 16'd7);
`endif
    stim = '{9'h1AA};
    do_reset();
    repeat (35) step();
    check("pre_rst_bit", 16'(data_out), 16'd1);
    #2 reset_L = 1'b0;
    #1;
    check("async_data_out", 16'(data_out), 16'd0);
    check("async_ready_out", 16'(ready_out), 16'd0);
    do_reset();
    repeat (4 * 8 + 3 * 8) step();
`ifdef TX_BYTE_COUNT_EN
    check("byte_count2", byte_count, 16'd1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
